dcache_bank_fill_sequencer: RTL



---
 rtl/dcache_bank_fill_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dcache_bank_fill_sequencer.sv
// dcache_bank_fill_sequencer
// Write-side sequencer for port B of the write-first data-bank RAM. It
// arbitrates a whole-bank clear, cache-line fills and single-word core
// loads/stores onto port B. All RAM-facing outputs are registered.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   clear_req                     pulse: zero the whole bank
//   fill_req_* / fill_line        line fill request and line index
//   fill_data_* / fill_data       fill beats, one word per accepted beat
//   fill_done                     pulses with the RAM write of the last beat
//   core_* / core_rvalid          core word access; rvalid aligned with RAM output
//   busy                          high while clearing or filling
//   ram_*_b                       RAM port B controls
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | writing zero to every address, one word per cycle
// S_IDLE  | arbitrating clear_req > fill_req_valid > core_valid
// S_FILL  | writing LINE_WORDS beats of the latched line
module dcache_bank_fill_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 512,
  parameter int LINE_WORDS     = 4,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW  = $clog2(DEPTH),
  localparam int LW  = $clog2(LINE_WORDS),
  localparam int LNW = AW - LW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  input  logic                  fill_req_valid,
  output logic                  fill_req_ready,
  input  logic [LNW-1:0]        fill_line,
  input  logic                  fill_data_valid,
  output logic                  fill_data_ready,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_done,
  input  logic                  core_valid,
  output logic                  core_ready,
  input  logic                  core_we,
  input  logic [AW-1:0]         core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_rvalid,
  output logic                  busy,
  output logic                  ram_en_b,
  output logic                  ram_we_b,
  output logic [AW-1:0]         ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_in_b
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_FILL} state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t                state, state_nx;
  logic [AW-1:0]         clr_cnt, clr_cnt_nx;
  logic [LNW-1:0]        line_q, line_nx;
  logic [LW-1:0]         word_cnt, word_cnt_nx;
  logic                  wr_en_nx, wr_we_nx, done_nx, load_nx, load_d1;
  logic [AW-1:0]         wr_addr_nx;
  logic [DATA_WIDTH-1:0] wr_data_nx;

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nx        = state;
    clr_cnt_nx      = clr_cnt;
    line_nx         = line_q;
    word_cnt_nx     = word_cnt;
    fill_req_ready  = 1'b0;
    fill_data_ready = 1'b0;
    core_ready      = 1'b0;
    wr_en_nx        = 1'b0;
    wr_we_nx        = 1'b0;
    wr_addr_nx      = ram_addr_b;      // address/data hold when idle to avoid toggling
    wr_data_nx      = ram_data_in_b;
    done_nx         = 1'b0;
    load_nx         = 1'b0;
    case (state)
      S_CLEAR: begin
        wr_en_nx   = 1'b1;
        wr_we_nx   = 1'b1;
        wr_addr_nx = clr_cnt;
        wr_data_nx = '0;
        clr_cnt_nx = clr_cnt + 1'b1;   // wraps to 0 after the last address
        if (&clr_cnt) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (clear_req) begin
          clr_cnt_nx = '0;
          state_nx   = S_CLEAR;
        end else if (fill_req_valid) begin
          fill_req_ready = 1'b1;
          line_nx        = fill_line;
          word_cnt_nx    = '0;
          state_nx       = S_FILL;
        end else begin
          core_ready = 1'b1;
          if (core_valid) begin
            wr_en_nx   = 1'b1;
            wr_we_nx   = core_we;
            wr_addr_nx = core_addr;
            wr_data_nx = core_wdata;
            load_nx    = ~core_we;
          end
        end
      end
      S_FILL: begin
        fill_data_ready = 1'b1;
        if (fill_data_valid) begin
          wr_en_nx    = 1'b1;
          wr_we_nx    = 1'b1;
          wr_addr_nx  = {line_q, word_cnt};
          wr_data_nx  = fill_data;
          word_cnt_nx = word_cnt + 1'b1;
          if (&word_cnt) begin
            done_nx  = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RST_STATE;
      clr_cnt       <= '0;
      line_q        <= '0;
      word_cnt      <= '0;
      ram_en_b      <= 1'b0;
      ram_we_b      <= 1'b0;
      ram_addr_b    <= '0;
      ram_data_in_b <= '0;
      fill_done     <= 1'b0;
      load_d1       <= 1'b0;
      core_rvalid   <= 1'b0;
    end else begin
      state         <= state_nx;
      clr_cnt       <= clr_cnt_nx;
      line_q        <= line_nx;
      word_cnt      <= word_cnt_nx;
      ram_en_b      <= wr_en_nx;
      ram_we_b      <= wr_we_nx;
      ram_addr_b    <= wr_addr_nx;
      ram_data_in_b <= wr_data_nx;
      fill_done     <= done_nx;
      // load data leaves the RAM one cycle after its enable is driven
      load_d1       <= load_nx;
      core_rvalid   <= load_d1;
    end
  end

endmodule
